mxm_operand_sequencer: RTL
==========================

# mxm_operand_sequencer

Operand streamer that sits directly upstream of `MxM`. It walks the (MxN)x(NxP) product in `MxM`'s consumption order: p outer, m middle, n inner. For each element it reads A[m*N+n] and X[p*N+n] from two synchronous-read operand memories. It presents one A/X pair per cycle, with no bubbles, plus dot-product framing and (m,p) tags so the downstream Y collector can index results.

## Interface
- `W`, 8, operand bit-width
- `M`, 200, rows of A / rows of Y
- `N`, 100, shared (dot-product) length
- `P`, 120, columns of Y (rows of X as stored)
- `AA`, $clog2(M*N), A memory address width
- `XA`, $clog2(N*P), X memory address width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset; `rst`=0 at a rising edge resets the block
- `start`  in  1  one-cycle request to begin a full M*N*P pass
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last pair is presented
- `a_addr`  out  AA  A memory read address
- `x_addr`  out  XA  X memory read address
- `a_rdata`  in  W  A memory data, valid one cycle after `a_addr`
- `x_rdata`  in  W  X memory data, valid one cycle after `x_addr`
- `A`, `X`  out  W  operand pair to `MxM`
- `out_valid`  out  1  `A`/`X` hold a real pair
- `first`  out  1  pair is n=0 of a dot product
- `last`  out  1  pair is n=N-1 of a dot product
- `tag_m`  out  $clog2(M)  m index of the current pair
- `tag_p`  out  $clog2(P)  p index of the current pair

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- **IDLE:** `start`=1 → STREAM. The address for (p,m,n)=(0,0,0) is issued in the same cycle.
- **STREAM:** issues one address pair per cycle.
  - `a_addr` = a_base + n, where a_base = m*N.
  - `x_addr` = x_base + n, where x_base = p*N.
  - Addresses are generated incrementally with no multipliers:
    - n wraps at N-1; m increments.
    - On m wrap: a_base returns to 0 and x_base += N; p increments.
  - After issuing (P-1,M-1,N-1) → DRAIN.
- **DRAIN:** 2 cycles, until the final pair is presented → DONE.
- **DONE:** `done`=1 for one cycle → IDLE.
- `first`, `last`, `tag_m`, `tag_p` travel in a 2-stage shadow pipeline aligned with the data.
- `start` while `busy` is ignored.
- While `out_valid`=0: `A`, `X`, `first`, `last`, `tag_*` are 0.

## Timing
- Reset values: all outputs 0; state IDLE; counters and bases 0.
- Addresses issued at cycle k → `A`/`X` registered at k+2, `out_valid`=1.
- Latency: `start` at cycle t → first pair at t+2 with `first`=1, `tag_m`=`tag_p`=0.
- Throughput: one pair per cycle, contiguous for M*N*P cycles. No gap at n, m or p wrap.
- `last` at cycle t+2+j*N+N-1 for dot product j. `done` is the cycle after the final pair.
- `busy` is 1 from t+1 through the cycle of `done`.
- N=1: `first` and `last` are both 1 on every pair.
- `rst`=0 mid-pass: next cycle is IDLE with all outputs 0, and the pipeline is flushed. No partial `done` is emitted.

## Configuration
- `MXM_SEQ_LOOP_EN`
  - **Defined:** after (P-1,M-1,N-1) the indices wrap to (0,0,0) and streaming continues without a bubble. `done` pulses for one cycle coincident with the last pair of each pass, while `out_valid` stays 1. `busy` stays 1 until reset. DRAIN/DONE states are not entered.
  - **Undefined:** single pass, as described above.

## Structure
- `mxm_pkg` holds:
  - the state enum `mxm_seq_state_t`;
  - default W/M/N/P localparams;
  - a `mxm_tag_t` struct {first, last, m, p} used for the shadow pipeline.
- One sub-module, `mxm_idx_counter`: nested n/m/p counters with a_base/x_base accumulation. Outputs are the address pair, wrap flags and `final`.

## Test plan
Test-plan runs use M=2, N=3, P=2 (beyond the basic run, the LOOP_EN run repeats the same parameters with the macro defined). Memories hold A[i]=i+1 and X[i]=0x10+i.

- **Basic run:** `start` at cycle 5 → pairs from cycle 7.
  - A sequence: 1,2,3,4,5,6,1,2,3,4,5,6.
  - X sequence: 0x10,0x11,0x12,0x10,0x11,0x12,0x13,0x14,0x15,0x13,0x14,0x15.
  - `first` at 7,10,13,16; `last` at 9,12,15,18; `done` at 19.
- **Tags:** (`tag_m`,`tag_p`) per dot product = (0,0),(1,0),(0,1),(1,1); zero when `out_valid`=0.
- **Start while busy:** `start` pulsed at cycle 10 → no effect; sequence identical to basic run.
- **Reset mid-pass:** `rst`=0 at cycle 11 → cycle 12 all outputs 0, state IDLE. A fresh `start` reproduces the basic run.
- **N=1 edge (M=2, N=1, P=2):** 4 pairs, each with `first`=`last`=1. A sequence 1,2,1,2; X sequence 0x10,0x10,0x11,0x11.
- **LOOP_EN build:** `out_valid` continuous across the pass boundary. `done` at cycle 18 and 30; the A sequence restarts with 1 at cycle 19.

Source files
------------

// File: rtl/mxm_pkg.sv
// Shared types and defaults for the MxM operand sequencer; no logic, no latency.
// Backpressure: not applicable.
package mxm_pkg;

    localparam int MXM_W     = 8;
    localparam int MXM_M     = 200;
    localparam int MXM_N     = 100;
    localparam int MXM_P     = 120;
    localparam int MXM_IDX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } mxm_seq_state_t;

    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [MXM_IDX_W-1:0] m;
        logic [MXM_IDX_W-1:0] p;
    } mxm_tag_t;

    // Index width that stays legal for a dimension of 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mxm_idx_counter.sv
// Nested n/m/p walker producing A/X read addresses by base accumulation; addresses are combinational from state.
// Backpressure: advances only when en is high.
module mxm_idx_counter
    import mxm_pkg::*;
#(
    parameter int M  = MXM_M,
    parameter int N  = MXM_N,
    parameter int P  = MXM_P,
    parameter int AA = $clog2(M * N),
    parameter int XA = $clog2(N * P)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [AA-1:0]         a_addr,
    output logic [XA-1:0]         x_addr,
    output logic [idx_w(M)-1:0]   m,
    output logic [idx_w(P)-1:0]   p,
    output logic                  n_first,
    output logic                  n_wrap,
    output logic                  m_wrap,
    output logic                  final_idx
);

    localparam int NW = idx_w(N);
    localparam int MW = idx_w(M);
    localparam int PW = idx_w(P);

    logic [NW-1:0] n;
    logic [AA-1:0] a_base;
    logic [XA-1:0] x_base;

    assign n_first   = (n == '0);
    assign n_wrap    = (n == NW'(N - 1));
    assign m_wrap    = n_wrap && (m == MW'(M - 1));
    assign final_idx = m_wrap && (p == PW'(P - 1));
    assign a_addr    = a_base + AA'(n);
    assign x_addr    = x_base + XA'(n);

    always_ff @(posedge clk) begin
        if (!rst) begin
            n      <= '0;
            m      <= '0;
            p      <= '0;
            a_base <= '0;
            x_base <= '0;
        end else if (en) begin
            if (!n_wrap) begin
                n <= n + 1'b1;
            end else begin
                n <= '0;
                if (!m_wrap) begin
                    m      <= m + 1'b1;
                    a_base <= a_base + AA'(N);
                end else begin
                    m      <= '0;
                    a_base <= '0;
                    // After the final element everything rolls back to (0,0,0).
                    if (final_idx) begin
                        p      <= '0;
                        x_base <= '0;
                    end else begin
                        p      <= p + 1'b1;
                        x_base <= x_base + XA'(N);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mxm_operand_sequencer.sv
// Streams A/X pairs to MxM in p,m,n order with first/last/(m,p) framing; pair lands 2 cycles after its address.
// No backpressure: one pair per cycle; MXM_SEQ_LOOP_EN makes passes repeat back to back.
module mxm_operand_sequencer
    import mxm_pkg::*;
#(
    parameter int W  = MXM_W,
    parameter int M  = MXM_M,
    parameter int N  = MXM_N,
    parameter int P  = MXM_P,
    parameter int AA = $clog2(M * N),
    parameter int XA = $clog2(N * P)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [AA-1:0]       a_addr,
    output logic [XA-1:0]       x_addr,
    input  logic [W-1:0]        a_rdata,
    input  logic [W-1:0]        x_rdata,
    output logic [W-1:0]        A,
    output logic [W-1:0]        X,
    output logic                out_valid,
    output logic                first,
    output logic                last,
    output logic [idx_w(M)-1:0] tag_m,
    output logic [idx_w(P)-1:0] tag_p
);

    localparam int MW = idx_w(M);
    localparam int PW = idx_w(P);

    mxm_seq_state_t state;
    logic           issue;
    logic           n_first;
    logic           n_wrap;
    logic           m_wrap;
    logic           final_idx;
    logic [MW-1:0]  m_idx;
    logic [PW-1:0]  p_idx;
    mxm_tag_t       tag_now;
    mxm_tag_t       s1_tag;
    logic           s1_vld;
`ifdef MXM_SEQ_LOOP_EN
    logic           s1_fin;
`endif

    assign issue = ((state == IDLE) && start) || (state == STREAM);

    mxm_idx_counter #(
        .M (M),
        .N (N),
        .P (P),
        .AA(AA),
        .XA(XA)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .en       (issue),
        .a_addr   (a_addr),
        .x_addr   (x_addr),
        .m        (m_idx),
        .p        (p_idx),
        .n_first  (n_first),
        .n_wrap   (n_wrap),
        .m_wrap   (m_wrap),
        .final_idx(final_idx)
    );

    // Tag leaves zero when no address is issued, so idle outputs fall out as 0.
    always_comb begin
        tag_now = '0;
        if (issue) begin
            tag_now.first = n_first;
            tag_now.last  = n_wrap;
            tag_now.m     = MXM_IDX_W'(m_idx);
            tag_now.p     = MXM_IDX_W'(p_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            s1_vld    <= 1'b0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            A         <= '0;
            X         <= '0;
            first     <= 1'b0;
            last      <= 1'b0;
            tag_m     <= '0;
            tag_p     <= '0;
`ifdef MXM_SEQ_LOOP_EN
            s1_fin    <= 1'b0;
`endif
        end else begin
            s1_vld    <= issue;
            s1_tag    <= tag_now;
            out_valid <= s1_vld;
            A         <= s1_vld ? a_rdata : '0;
            X         <= s1_vld ? x_rdata : '0;
            first     <= s1_tag.first;
            last      <= s1_tag.last;
            tag_m     <= s1_tag.m[MW-1:0];
            tag_p     <= s1_tag.p[PW-1:0];
`ifdef MXM_SEQ_LOOP_EN
            // done rides with the last pair of every pass; streaming never stops.
            s1_fin <= issue && final_idx && m_wrap;
            done   <= s1_fin;
            if ((state == IDLE) && start) begin
                state <= STREAM;
                busy  <= 1'b1;
            end
`else
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= final_idx ? DRAIN : STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (final_idx) state <= DRAIN;
                end
                DRAIN: begin
                    // The last pair is in the output stage once stage 1 empties.
                    if (!s1_vld) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule
